// File: rtl/override_pkg.sv
// Shared definitions for the override command path (controller and servo driver).
// Holds direction encodings, request/position widths, default timing constants,
// the request record type and the saturating position step helper.
package override_pkg;

  localparam int unsigned POS_W = 8;
  localparam int unsigned VAL_W = 8;
  localparam int unsigned REQ_W = 1 + VAL_W;

  localparam logic DIR_INC = 1'b0;
  localparam logic DIR_DEC = 1'b1;

  // Defaults sized for a 27 MHz system clock and a 20 ms servo frame.
  localparam int unsigned DEF_FRAME_CYCLES     = 540000;
  localparam int unsigned DEF_PULSE_MIN_CYCLES = 27000;
  localparam int unsigned DEF_STEP_CYCLES      = 105;
  localparam int unsigned DEF_CENTER_POS       = 128;
  localparam int unsigned DEF_MIN_POS          = 16;
  localparam int unsigned DEF_MAX_POS          = 240;
  localparam int unsigned DEF_MAX_SLEW         = 8;

  // One step/GO request as carried on the (dir, val, done) interface.
  typedef struct packed {
    logic             dir;
    logic [VAL_W-1:0] val;
  } req_t;

  // Apply a signed step to a position and saturate to [lo, hi].
  // Two guard bits keep pos+mag (up to 510) and pos-mag (down to -255) exact.
  function automatic logic [POS_W-1:0] step_pos(
    input logic [POS_W-1:0] pos,
    input logic             dir,
    input logic [VAL_W-1:0] mag,
    input logic [POS_W-1:0] lo,
    input logic [POS_W-1:0] hi
  );
    logic signed [POS_W+1:0] sum;
    if (dir == DIR_DEC) begin
      sum = $signed({2'b00, pos}) - $signed({2'b00, mag});
    end else begin
      sum = $signed({2'b00, pos}) + $signed({2'b00, mag});
    end
    if (sum < $signed({2'b00, lo})) begin
      return lo;
    end else if (sum > $signed({2'b00, hi})) begin
      return hi;
    end else begin
      return sum[POS_W-1:0];
    end
  endfunction

endpackage

// File: rtl/servo_pwm_gen.sv
// Servo frame timebase: free-running frame counter, pulse compare and update tick.
// Ports:
//   clock, reset     - system clock, asynchronous active-low reset
//   pulse_width      - pulse length in clocks; owner changes it only at frame end
//   pwm              - registered servo pulse (lags the counter by one clock)
//   frame_tick       - high for the single cycle in which the counter is at its last value
module servo_pwm_gen
  import override_pkg::*;
#(
  parameter int unsigned FRAME_CYCLES = DEF_FRAME_CYCLES,
  parameter int unsigned CNT_W        = $clog2(FRAME_CYCLES)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] pulse_width,
  output logic             pwm,
  output logic             frame_tick
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_CYCLES - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             pwm_q, pwm_d;
  logic             tick_q, tick_d;

  // Next counter value, pulse level and update-cycle flag.
  always_comb begin
    count_d = count_q + CNT_W'(1);
    pwm_d   = 1'b0;
    tick_d  = 1'b0;
    if (count_q == LAST_CNT) begin
      count_d = '0;
    end
    // The update cycle is always low even for a degenerate full-frame width.
    if ((count_q < pulse_width) && (count_q != LAST_CNT)) begin
      pwm_d = 1'b1;
    end
    // Registered so the tick is high exactly while count_q sits on LAST_CNT.
    if (count_d == LAST_CNT) begin
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      pwm_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      pwm_q   <= pwm_d;
      tick_q  <= tick_d;
    end
  end

  assign pwm        = pwm_q;
  assign frame_tick = tick_q;

endmodule

// File: rtl/override_servo_driver.sv
// Consumer of the override (dir, val, done) step/GO stream. Buffers one pending
// request, applies it once per servo frame to a saturating pan position, and
// drives the hobby-servo PWM pin from that position.
// Optional build macro: OVERRIDE_SLEW_EN limits each applied step to MAX_SLEW.
// Ports:
//   clock, reset  - system clock, asynchronous active-low reset
//   dir, val      - request direction (0 inc, 1 dec) and magnitude
//   done          - request valid, may be held high (GO mode)
//   pwm           - servo pulse
//   position      - applied pan position
//   at_min/at_max - position sits on a saturation limit (combinational)
//   frame_tick    - one-cycle pulse on the update cycle
//   overwrite     - one-cycle pulse when an unapplied pending request is replaced
module override_servo_driver
  import override_pkg::*;
#(
  parameter int unsigned      FRAME_CYCLES     = DEF_FRAME_CYCLES,
  parameter int unsigned      PULSE_MIN_CYCLES = DEF_PULSE_MIN_CYCLES,
  parameter int unsigned      STEP_CYCLES      = DEF_STEP_CYCLES,
  parameter logic [POS_W-1:0] CENTER_POS       = POS_W'(DEF_CENTER_POS),
  parameter logic [POS_W-1:0] MIN_POS          = POS_W'(DEF_MIN_POS),
  parameter logic [POS_W-1:0] MAX_POS          = POS_W'(DEF_MAX_POS),
  parameter logic [VAL_W-1:0] MAX_SLEW         = VAL_W'(DEF_MAX_SLEW)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dir,
  input  logic [VAL_W-1:0] val,
  input  logic             done,
  output logic             pwm,
  output logic [POS_W-1:0] position,
  output logic             at_min,
  output logic             at_max,
  output logic             frame_tick,
  output logic             overwrite
);

  localparam int unsigned CNT_W     = $clog2(FRAME_CYCLES);
  localparam int unsigned RST_WIDTH = PULSE_MIN_CYCLES + 32'(CENTER_POS) * STEP_CYCLES;

  // Elaboration guard: the longest pulse must end before the update cycle.
  if (FRAME_CYCLES <= PULSE_MIN_CYCLES + 255 * STEP_CYCLES) begin : g_bad_frame
    $error("FRAME_CYCLES too short for the maximum pulse width");
  end
  if ((MIN_POS > CENTER_POS) || (CENTER_POS > MAX_POS) || (MAX_SLEW == '0)) begin : g_bad_pos
    $error("position limits or slew limit inconsistent");
  end

  req_t             in_req;
  req_t             pend_q, pend_d;
  logic             pend_valid_q, pend_valid_d;
  logic             overwrite_q, overwrite_d;
  logic [POS_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic             update;
  logic             apply;
  req_t             src;
  logic [VAL_W-1:0] mag;

  assign in_req = req_t'({dir, val});

  servo_pwm_gen #(
    .FRAME_CYCLES (FRAME_CYCLES),
    .CNT_W        (CNT_W)
  ) u_pwm (
    .clock       (clock),
    .reset       (reset),
    .pulse_width (width_q),
    .pwm         (pwm),
    .frame_tick  (update)
  );

  // Pending-slot capture outside the update cycle; request application inside it.
  always_comb begin
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    overwrite_d  = 1'b0;
    pos_d        = pos_q;
    width_d      = width_q;
    apply        = 1'b0;
    src          = pend_q;
    mag          = '0;

    if (update) begin
      pend_valid_d = 1'b0;
      // A request on the update cycle bypasses (and discards) the pending slot.
      if (done) begin
        apply = 1'b1;
        src   = in_req;
      end else if (pend_valid_q) begin
        apply = 1'b1;
        src   = pend_q;
      end
`ifdef OVERRIDE_SLEW_EN
      mag = (src.val > MAX_SLEW) ? MAX_SLEW : src.val;
`else
      mag = src.val;
`endif
      if (apply) begin
        pos_d   = step_pos(pos_q, src.dir, mag, MIN_POS, MAX_POS);
        width_d = CNT_W'(PULSE_MIN_CYCLES) + CNT_W'(pos_d) * CNT_W'(STEP_CYCLES);
      end
    end else if (done) begin
      // Latest request wins; a val of 0 here acts as STOP.
      pend_d       = in_req;
      pend_valid_d = 1'b1;
      overwrite_d  = pend_valid_q;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      overwrite_q  <= 1'b0;
      pos_q        <= CENTER_POS;
      width_q      <= CNT_W'(RST_WIDTH);
    end else begin
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      overwrite_q  <= overwrite_d;
      pos_q        <= pos_d;
      width_q      <= width_d;
    end
  end

  assign position   = pos_q;
  assign at_min     = (pos_q == MIN_POS);
  assign at_max     = (pos_q == MAX_POS);
  assign frame_tick = update;
  assign overwrite  = overwrite_q;

endmodule

// File: tb/tb_override_servo_driver.sv
// Scoreboard bench for override_servo_driver with a reduced frame (400 clocks).
module tb_override_servo_driver;
  import override_pkg::*;

  localparam int FRAME = 400;
  localparam int PMIN  = 10;
  localparam int STEP  = 1;
  localparam int CPOS  = 128;
  localparam int LO    = 16;
  localparam int HI    = 240;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       dir   = 1'b0;
  logic [7:0] val   = 8'd0;
  logic       done  = 1'b0;
  logic       pwm, at_min, at_max, frame_tick, overwrite;
  logic [7:0] position;

  always #5 clock = ~clock;

  override_servo_driver #(
    .FRAME_CYCLES     (FRAME),
    .PULSE_MIN_CYCLES (PMIN),
    .STEP_CYCLES      (STEP),
    .CENTER_POS       (8'd128),
    .MIN_POS          (8'd16),
    .MAX_POS          (8'd240),
    .MAX_SLEW         (8'd8)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .dir        (dir),
    .val        (val),
    .done       (done),
    .pwm        (pwm),
    .position   (position),
    .at_min     (at_min),
    .at_max     (at_max),
    .frame_tick (frame_tick),
    .overwrite  (overwrite)
  );

  typedef struct {
    int pos;
    int ow;
    int width;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   frames_checked = 0;

  // Reference model state: position, latest unapplied request, clock index in frame.
  int m_pos  = CPOS;
  int m_k    = 0;
  bit m_pv   = 1'b0;
  bit m_pdir = 1'b0;
  int m_pval = 0;
  int m_ow   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ref_apply(input int pos, input bit d, input int v);
    int m;
    int n;
    m = v;
`ifdef OVERRIDE_SLEW_EN
    if (m > 8) m = 8;
`endif
    n = d ? pos - m : pos + m;
    if (n < LO) n = LO;
    if (n > HI) n = HI;
    return n;
  endfunction

  function automatic void model_reset();
    m_pos = CPOS;
    m_pv  = 1'b0;
    m_ow  = 0;
    m_k   = 0;
  endfunction

  // Present one clock of input and advance the model by the same clock.
  task automatic drive(input bit d, input bit di, input int v);
    int phase;
    exp_t e;
    done  = d;
    dir   = di;
    val   = 8'(v);
    phase = m_k % FRAME;
    if (phase == FRAME - 1) begin
      if (d) m_pos = ref_apply(m_pos, di, v);
      else if (m_pv) m_pos = ref_apply(m_pos, m_pdir, m_pval);
      m_pv    = 1'b0;
      e.pos   = m_pos;
      e.ow    = m_ow;
      e.width = PMIN + m_pos * STEP;
      sb_q.push_back(e);
      m_ow = 0;
    end else if (d) begin
      if (m_pv) m_ow++;
      m_pv   = 1'b1;
      m_pdir = di;
      m_pval = v;
    end
    @(negedge clock);
    m_k++;
  endtask

  task automatic idle_to(input int phase);
    while ((m_k % FRAME) != phase) drive(1'b0, 1'b0, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 0);
  endtask

  // Monitor: per frame, compare pulse length, overwrite count, period and new position.
  initial begin
    int   since;
    int   pcnt;
    int   ocnt;
    int   cur_w;
    bit   chk;
    exp_t e;
    since = 1; pcnt = 0; ocnt = 0; cur_w = PMIN + CPOS * STEP; chk = 1'b0;
    forever begin
      @(negedge clock);
      if (!reset) begin
        since = 1; pcnt = 0; ocnt = 0; cur_w = PMIN + CPOS * STEP; chk = 1'b0;
      end else begin
        if (chk) begin
          if (sb_q.size() == 0) begin
            check("sb_underflow", 32'(sb_q.size()), 32'd1);
          end else begin
            e = sb_q.pop_front();
            check("position", 32'(position), 32'(e.pos));
            check("at_min", 32'(at_min), 32'(e.pos == LO));
            check("at_max", 32'(at_max), 32'(e.pos == HI));
            check("overwrite_count", 32'(ocnt), 32'(e.ow));
            check("pwm_high_clocks", 32'(pcnt), 32'(cur_w));
            cur_w = e.width;
            frames_checked++;
          end
          since = 0; pcnt = 0; ocnt = 0; chk = 1'b0;
        end
        since++;
        pcnt += int'(pwm);
        ocnt += int'(overwrite);
        if (frame_tick === 1'b1) begin
          check("frame_period", 32'(since), 32'(FRAME));
          chk = 1'b1;
        end else if (since == FRAME + 10) begin
          check("frame_tick_timeout", 32'(since), 32'(FRAME));
        end
      end
    end
  end

  // Stimulus
  initial begin
    int w;
    reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_pwm", 32'(pwm), 32'd0);
    check("rst_position", 32'(position), 32'(CPOS));
    check("rst_frame_tick", 32'(frame_tick), 32'd0);
    check("rst_overwrite", 32'(overwrite), 32'd0);
    check("rst_at_min", 32'(at_min), 32'd0);
    check("rst_at_max", 32'(at_max), 32'd0);
    reset = 1'b1;
    model_reset();

    // Idle frames, then a single mid-frame step and a following idle frame.
    idle(2 * FRAME);
    idle_to(200);
    drive(1'b1, DIR_INC, 2);
    idle_to(0);
    idle(FRAME);

    // GO mode decrement for five frames.
    repeat (5 * FRAME) drive(1'b1, DIR_DEC, 1);
    idle_to(0);

    // Saturation at both limits.
    idle_to(100);
    drive(1'b1, DIR_INC, 200);
    idle_to(100);
    drive(1'b1, DIR_DEC, 255);
    idle_to(0);

    // Two requests in one frame; then an update-cycle request beats a pending one.
    idle_to(50);
    drive(1'b1, DIR_INC, 5);
    idle_to(150);
    drive(1'b1, DIR_DEC, 3);
    idle_to(100);
    drive(1'b1, DIR_INC, 9);
    idle_to(FRAME - 1);
    drive(1'b1, DIR_DEC, 1);
    // STOP: a val-0 request cancels an earlier pending step.
    idle_to(100);
    drive(1'b1, DIR_INC, 20);
    drive(1'b1, DIR_INC, 0);
    idle_to(0);
    // Large request, exercising the slew limit when it is enabled.
    idle_to(10);
    drive(1'b1, DIR_INC, 50);
    idle_to(0);

    // Randomized frames.
    for (int f = 0; f < 20; f++) begin
      int mode;
      mode = int'($urandom_range(0, 3));
      for (int c = 0; c < FRAME; c++) begin
        case (mode)
          0: begin
            if ($urandom_range(0, 99) < 2) drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 255)));
            else drive(1'b0, 1'b0, 0);
          end
          1: drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
          2: begin
            if (c >= FRAME - 3 || c == 77) drive(1'b1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 40)));
            else drive(1'b0, 1'b0, 0);
          end
          default: drive(1'b0, 1'b0, 0);
        endcase
      end
    end

    // Asynchronous reset in the middle of a pulse.
    idle_to(100);
    drive(1'b1, DIR_INC, 255);
    idle_to(100);
    drive(1'b1, DIR_DEC, 40);
    idle_to(0);
    idle_to(50);
    w = PMIN + m_pos * STEP;
    check("pwm_pre_reset", 32'(pwm), 32'(49 < w));
    #2 reset = 1'b0;
    #1;
    check("async_rst_pwm", 32'(pwm), 32'd0);
    check("async_rst_position", 32'(position), 32'(CPOS));
    check("async_rst_at_max", 32'(at_max), 32'd0);
    sb_q.delete();
    done = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset = 1'b1;
    model_reset();
    // The pending request from before reset must be gone: nothing applied.
    idle(2 * FRAME);
    idle(2);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    if (frames_checked < 30) check("frames_checked", 32'(frames_checked), 32'd30);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
